sfm_ctrl_fsm: RTL and testbench

- Top-level job sequencer for the softmax accelerator.
- On a start pulse from the register file it decodes COMMANDS (bits CMD_ACC_ONLY=0, CMD_DIV_ONLY=1, CMD_PARTIAL=2).
- It then drives the datapath through clear, accumulation (max + exp-sum), reduction and division passes, and requests one input stream per pass from the streamer.
- It owns the datapath control bits (disable_max, dividing, clear_regs, acc_finished) and consumes the datapath flags (datapath_busy, reducing).

---
 rtl/sfm_ctrl_fsm_if.sv | 44 ++++
 rtl/sfm_ctrl_fsm.sv | 198 +++++++++++++++++++
 tb/tb_sfm_ctrl_fsm.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sfm_ctrl_fsm_if.sv
// -----------------------------------------------------------------------------
// sfm_stream_if
// Request/grant/done link between the softmax job sequencer (master) and the
// input streamer (slave).
//
// Handshake: the master raises stream_req_o together with a stable
// stream_div_o / stream_len_o and holds all three until it samples
// stream_gnt_i high on a rising clock edge. That edge is the transfer of the
// request. stream_req_o is low from the cycle after the grant. The streamer
// later pulses stream_done_i for one cycle when the pass has finished. A done
// pulse in the same cycle as the grant belongs to that pass.
//
// Signals (direction as seen from the master / sequencer):
//   stream_req_o   out  request one stream pass
//   stream_div_o   out  pass type: 0 = read-only accumulate, 1 = read+write divide
//   stream_len_o   out  number of elements in the pass
//   stream_gnt_i   in   streamer accepted the request
//   stream_done_i  in   streamer finished the pass (one-cycle pulse)
// -----------------------------------------------------------------------------
interface sfm_stream_if #(
  parameter int LEN_W = 32
);
  logic             stream_req_o;
  logic             stream_div_o;
  logic [LEN_W-1:0] stream_len_o;
  logic             stream_gnt_i;
  logic             stream_done_i;

  modport master (
    output stream_req_o,
    output stream_div_o,
    output stream_len_o,
    input  stream_gnt_i,
    input  stream_done_i
  );

  modport slave (
    input  stream_req_o,
    input  stream_div_o,
    input  stream_len_o,
    output stream_gnt_i,
    output stream_done_i
  );
endinterface

// File: rtl/sfm_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// sfm_ctrl_fsm
// Top-level job sequencer of the softmax accelerator. A start pulse latches
// TOT_LEN and COMMANDS, then the sequencer walks the datapath through the
// clear, accumulation (max + exp-sum), reduction and division passes,
// requesting one input stream per pass from the streamer.
//
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   start_i             job trigger pulse (only honoured in IDLE)
//   abort_i             synchronous job abort (any non-IDLE state)
//   tot_len_i           TOT_LEN register value
//   commands_i          COMMANDS bits: 0 = ACC_ONLY, 1 = DIV_ONLY, 2 = PARTIAL
//   strm                stream request/grant/done link (master side)
//   datapath_busy_i     datapath still has elements in flight
//   reducing_i          accumulator reduction tree active
//   clear_regs_o        clear datapath registers (one-cycle pulse)
//   disable_max_o       freeze the running max (division pass)
//   dividing_o          datapath is in the division pass
//   acc_finished_o      accumulation finished, start reduction (pulse)
//   busy_o              job in progress
//   done_o              job complete (one-cycle pulse)
//   err_o               last job had an illegal command combination
//   cycles_o            busy cycles of the last/current job (saturating)
//   state_dbg_o         current sequencer state encoding
//
// Every output is a flop: the next state is decoded combinationally and the
// outputs are registered from that decode, so no input reaches an output
// without passing a clock edge.
// -----------------------------------------------------------------------------
module sfm_ctrl_fsm #(
  parameter int LEN_W = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [LEN_W-1:0] tot_len_i,
  input  logic [2:0]       commands_i,
  sfm_stream_if.master     strm,
  input  logic             datapath_busy_i,
  input  logic             reducing_i,
  output logic             clear_regs_o,
  output logic             disable_max_o,
  output logic             dividing_o,
  output logic             acc_finished_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [CNT_W-1:0] cycles_o,
  output logic [3:0]       state_dbg_o
);

  localparam int CMD_ACC_ONLY = 0;
  localparam int CMD_DIV_ONLY = 1;
  localparam int CMD_PARTIAL  = 2;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_CLEAR     = 4'd1,
    ST_ACC_REQ   = 4'd2,
    ST_ACC_WAIT  = 4'd3,
    ST_RED_PULSE = 4'd4,
    ST_RED_WAIT  = 4'd5,
    ST_DIV_REQ   = 4'd6,
    ST_DIV_WAIT  = 4'd7,
    ST_DONE      = 4'd8
  } state_t;

  state_t           state_q;
  state_t           state_n;
  logic             done_seen_q;
  logic             done_seen_n;
  logic             abort_take;
  logic             acc_only_q;
  logic             partial_q;
  logic [LEN_W-1:0] len_q;
  logic             stream_req_q;
  logic             stream_div_q;

  assign strm.stream_req_o = stream_req_q;
  assign strm.stream_div_o = stream_div_q;
  assign strm.stream_len_o = len_q;
  assign state_dbg_o       = state_q;

  // Next-state decode. Abort outranks every other transition. The done bit of
  // a stream pass is sticky from the grant cycle onward; the live pulse is
  // OR-ed in so a done arriving while the datapath is already idle is not
  // delayed by an extra cycle.
  always_comb begin
    state_n     = state_q;
    done_seen_n = 1'b0;
    abort_take  = 1'b0;
    if (state_q != ST_IDLE && abort_i) begin
      state_n    = ST_IDLE;
      abort_take = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            if (tot_len_i == '0) begin
              state_n = ST_DONE;
            end else if (commands_i[CMD_ACC_ONLY] && commands_i[CMD_DIV_ONLY]) begin
              state_n = ST_DONE;
            end else if (commands_i[CMD_DIV_ONLY]) begin
              state_n = ST_DIV_REQ;
            end else if (commands_i[CMD_PARTIAL]) begin
              state_n = ST_ACC_REQ;
            end else begin
              state_n = ST_CLEAR;
            end
          end
        end
        ST_CLEAR: state_n = ST_ACC_REQ;
        ST_ACC_REQ: begin
          if (strm.stream_gnt_i) begin
            state_n     = ST_ACC_WAIT;
            done_seen_n = strm.stream_done_i;
          end
        end
        ST_ACC_WAIT: begin
          done_seen_n = done_seen_q | strm.stream_done_i;
          if (done_seen_n && !datapath_busy_i) begin
            // A partial job stops after accumulation; the host reads the
            // partial sums without reduction.
            state_n = partial_q ? ST_DONE : ST_RED_PULSE;
          end
        end
        ST_RED_PULSE: state_n = ST_RED_WAIT;
        ST_RED_WAIT: begin
          if (!reducing_i && !datapath_busy_i) begin
            state_n = acc_only_q ? ST_DONE : ST_DIV_REQ;
          end
        end
        ST_DIV_REQ: begin
          if (strm.stream_gnt_i) begin
            state_n     = ST_DIV_WAIT;
            done_seen_n = strm.stream_done_i;
          end
        end
        ST_DIV_WAIT: begin
          done_seen_n = done_seen_q | strm.stream_done_i;
          if (done_seen_n && !datapath_busy_i) begin
            state_n = ST_DONE;
          end
        end
        ST_DONE: state_n = ST_IDLE;
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= ST_IDLE;
      done_seen_q    <= 1'b0;
      acc_only_q     <= 1'b0;
      partial_q      <= 1'b0;
      len_q          <= '0;
      err_o          <= 1'b0;
      cycles_o       <= '0;
      stream_req_q   <= 1'b0;
      stream_div_q   <= 1'b0;
      clear_regs_o   <= 1'b0;
      disable_max_o  <= 1'b0;
      dividing_o     <= 1'b0;
      acc_finished_o <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
    end else begin
      state_q     <= state_n;
      done_seen_q <= done_seen_n;

      if (state_q == ST_IDLE && start_i) begin
        acc_only_q <= commands_i[CMD_ACC_ONLY];
        partial_q  <= commands_i[CMD_PARTIAL];
        len_q      <= tot_len_i;
        err_o      <= (tot_len_i != '0) && commands_i[CMD_ACC_ONLY] &&
                      commands_i[CMD_DIV_ONLY];
        cycles_o   <= '0;
      end else if (busy_o && cycles_o != {CNT_W{1'b1}}) begin
        cycles_o <= cycles_o + 1'b1;
      end

      // Registered decodes of the state being entered.
      busy_o         <= (state_n != ST_IDLE) && (state_n != ST_DONE);
      stream_req_q   <= (state_n == ST_ACC_REQ) || (state_n == ST_DIV_REQ);
      stream_div_q   <= (state_n == ST_DIV_REQ) || (state_n == ST_DIV_WAIT);
      dividing_o     <= (state_n == ST_DIV_REQ) || (state_n == ST_DIV_WAIT);
      disable_max_o  <= (state_n == ST_DIV_REQ) || (state_n == ST_DIV_WAIT);
      clear_regs_o   <= (state_n == ST_CLEAR) || abort_take;
      acc_finished_o <= (state_n == ST_RED_PULSE);
      done_o         <= (state_n == ST_DONE);
    end
  end

endmodule

// File: tb/tb_sfm_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_sfm_ctrl_fsm
// Job-level bench for the softmax sequencer. Each job is planned up front:
// the streamer/datapath response delays are chosen, and from the sequencing
// rules the bench builds the expected per-cycle output picture as a list of
// phase segments (clear, request, wait, reduce, done) plus the input schedule
// that realises those delays. The run then replays the schedule and compares
// every cycle's outputs against the plan.
// -----------------------------------------------------------------------------
module tb_sfm_ctrl_fsm;

  localparam int LEN_W = 32;
  localparam int CNT_W = 32;

  // Expected output picture bits:
  // [7] busy [6] req [5] div [4] clear [3] acc_fin [2] dividing [1] disable_max [0] done
  localparam logic [7:0] V_IDLE     = 8'b0000_0000;
  localparam logic [7:0] V_CLEAR    = 8'b1001_0000;
  localparam logic [7:0] V_REQ_ACC  = 8'b1100_0000;
  localparam logic [7:0] V_WAIT_ACC = 8'b1000_0000;
  localparam logic [7:0] V_ACCF     = 8'b1000_1000;
  localparam logic [7:0] V_REDW     = 8'b1000_0000;
  localparam logic [7:0] V_REQ_DIV  = 8'b1110_0110;
  localparam logic [7:0] V_WAIT_DIV = 8'b1010_0110;
  localparam logic [7:0] V_DONE     = 8'b0000_0001;
  localparam logic [7:0] V_ABORT    = 8'b0001_0000;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_ni;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic             start_i;
  logic             abort_i;
  logic [LEN_W-1:0] tot_len_i;
  logic [2:0]       commands_i;
  logic             datapath_busy_i;
  logic             reducing_i;
  logic             clear_regs_o;
  logic             disable_max_o;
  logic             dividing_o;
  logic             acc_finished_o;
  logic             busy_o;
  logic             done_o;
  logic             err_o;
  logic [CNT_W-1:0] cycles_o;
  logic [3:0]       state_dbg_o;

  sfm_stream_if #(.LEN_W(LEN_W)) strm ();

  sfm_ctrl_fsm #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .start_i        (start_i),
    .abort_i        (abort_i),
    .tot_len_i      (tot_len_i),
    .commands_i     (commands_i),
    .strm           (strm),
    .datapath_busy_i(datapath_busy_i),
    .reducing_i     (reducing_i),
    .clear_regs_o   (clear_regs_o),
    .disable_max_o  (disable_max_o),
    .dividing_o     (dividing_o),
    .acc_finished_o (acc_finished_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o),
    .cycles_o       (cycles_o),
    .state_dbg_o    (state_dbg_o)
  );

  // ---------------- scoreboard state ----------------
  int unsigned      checks;
  int unsigned      errors;
  logic [7:0]       exp_q[$];
  bit [255:0]       gnt_s, done_s, busy_s, red_s, start_s, abort_s;
  int unsigned      cyc_exp;
  logic             err_exp;
  logic [LEN_W-1:0] len_exp;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] out_vec();
    return {busy_o, strm.stream_req_o, strm.stream_div_o, clear_regs_o,
            acc_finished_o, dividing_o, disable_max_o, done_o};
  endfunction

  task automatic check_cycle(input logic [7:0] exp_v);
    check_eq("outputs", 64'(out_vec()), 64'(exp_v));
    check_eq("cycles", 64'(cycles_o), 64'(cyc_exp));
    check_eq("err", 64'(err_o), 64'(err_exp));
    check_eq("stream_len", 64'(strm.stream_len_o), 64'(len_exp));
    if (exp_v[7]) cyc_exp++;
  endtask

  // ---------------- plan builders ----------------
  task automatic seg(input int n, input logic [7:0] v);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  // One stream pass: request visible for g+1 cycles, grant on the last of
  // them, done d cycles after the grant, datapath busy from the grant until
  // bt cycles after done. The pass ends on the first cycle busy is low.
  task automatic add_pass(input bit is_div, input int g, input int d, input int bt,
                          output int wait_first);
    int a;
    a = exp_q.size();
    seg(g + 1, is_div ? V_REQ_DIV : V_REQ_ACC);
    gnt_s[a + 1 + g]      = 1'b1;
    done_s[a + 1 + g + d] = 1'b1;
    for (int e = a + 1 + g; e <= a + 1 + g + d + bt; e++) busy_s[e] = 1'b1;
    wait_first = exp_q.size();
    seg(d + bt + 1, is_div ? V_WAIT_DIV : V_WAIT_ACC);
  endtask

  // ---------------- driver ----------------
  // abort_mode: 0 none, 1 random point in the job, 2 inside the divide wait.
  task automatic run_job(input logic [2:0] cmd, input logic [LEN_W-1:0] len,
                         input int g1, input int d1, input int bt1, input int rr,
                         input int g2, input int d2, input int bt2,
                         input int abort_mode, input bit mid_start, input bit rst_in_wait);
    int acc_wait = -1;
    int div_wait = -1;
    int x;
    int n_last;
    int abort_at = 0;
    int limit;
    gnt_s = '0; done_s = '0; busy_s = '0; red_s = '0; start_s = '0; abort_s = '0;
    exp_q.delete();

    if (len == '0 || (cmd[0] && cmd[1])) begin
      seg(1, V_DONE);
    end else begin
      if (cmd[1]) begin
        add_pass(1'b1, g2, d2, bt2, div_wait);
      end else begin
        if (!cmd[2]) seg(1, V_CLEAR);
        add_pass(1'b0, g1, d1, bt1, acc_wait);
        if (!cmd[2]) begin
          x = exp_q.size();
          seg(1, V_ACCF);
          for (int e = x + 1; e <= x + 1 + rr; e++) red_s[e] = 1'b1;
          seg(rr + 1, V_REDW);
          if (!cmd[0]) add_pass(1'b1, g2, d2, bt2, div_wait);
        end
      end
      seg(1, V_DONE);
    end
    n_last = exp_q.size() - 1;

    if (abort_mode == 1 && n_last >= 1) abort_at = int'($urandom_range(1, n_last));
    if (abort_mode == 2 && div_wait >= 0) abort_at = div_wait + 1;
    if (abort_at > 0) begin
      while (exp_q.size() > abort_at) void'(exp_q.pop_back());
      exp_q.push_back(V_ABORT);
      abort_s[abort_at] = 1'b1;
    end
    exp_q.push_back(V_IDLE);

    start_s[0] = 1'b1;
    if (mid_start) begin
      limit = (abort_at > 0) ? abort_at - 1 : n_last;
      for (int e = 1; e <= limit; e++)
        if (e == 1 || $urandom_range(0, 3) == 0) start_s[e] = 1'b1;
    end

    tot_len_i  = len;
    commands_i = cmd;
    len_exp    = len;
    err_exp    = (len != '0) && cmd[0] && cmd[1];
    cyc_exp    = 0;

    for (int k = 0; k < exp_q.size(); k++) begin
      start_i         = start_s[k];
      abort_i         = abort_s[k];
      strm.stream_gnt_i  = gnt_s[k];
      strm.stream_done_i = done_s[k];
      datapath_busy_i = busy_s[k];
      reducing_i      = red_s[k];
      // TOT_LEN/COMMANDS may change after the start edge; the latched copy rules.
      if (k == 1) begin
        tot_len_i  = LEN_W'($urandom);
        commands_i = 3'($urandom_range(0, 7));
      end
      @(posedge clk);
      @(negedge clk);
      check_cycle(exp_q[k]);
      if (rst_in_wait && k == acc_wait) begin
        #2 rst_ni = 1'b0;
        #1;
        check_eq("rst_outputs", 64'(out_vec()), 64'(V_IDLE));
        check_eq("rst_cycles", 64'(cycles_o), 64'd0);
        check_eq("rst_err", 64'(err_o), 64'd0);
        check_eq("rst_len", 64'(strm.stream_len_o), 64'd0);
        cyc_exp = 0;
        err_exp = 1'b0;
        len_exp = '0;
        @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        break;
      end
    end
    start_i = 1'b0; abort_i = 1'b0;
    strm.stream_gnt_i = 1'b0; strm.stream_done_i = 1'b0;
    datapath_busy_i = 1'b0; reducing_i = 1'b0;
  endtask

  // Idle cycles with noise on inputs that must be ignored in IDLE.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      start_i            = 1'b0;
      abort_i            = 1'($urandom_range(0, 1));
      strm.stream_gnt_i  = 1'($urandom_range(0, 1));
      strm.stream_done_i = 1'($urandom_range(0, 1));
      datapath_busy_i    = 1'($urandom_range(0, 1));
      reducing_i         = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      check_cycle(V_IDLE);
    end
    abort_i = 1'b0; strm.stream_gnt_i = 1'b0; strm.stream_done_i = 1'b0;
    datapath_busy_i = 1'b0; reducing_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence + report ----------------
  initial begin
    logic [2:0]       rc;
    logic [LEN_W-1:0] rl;
    checks = 0; errors = 0;
    cyc_exp = 0; err_exp = 1'b0; len_exp = '0;
    rst_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0;
    tot_len_i = '0; commands_i = '0;
    strm.stream_gnt_i = 1'b0; strm.stream_done_i = 1'b0;
    datapath_busy_i = 1'b0; reducing_i = 1'b0;
    #1;
    check_eq("reset_outputs", 64'(out_vec()), 64'(V_IDLE));
    check_eq("reset_cycles", 64'(cycles_o), 64'd0);
    check_eq("reset_len", 64'(strm.stream_len_o), 64'd0);
    check_eq("reset_err", 64'(err_o), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    idle(2);

    // full run, grant after 2, done after 40, reduction 5 cycles
    run_job(3'b000, 64, 2, 40, 1, 5, 2, 40, 1, 0, 1'b0, 1'b0);
    idle(1);
    // ACC_ONLY|PARTIAL
    run_job(3'b101, 16, 1, 5, 1, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    // DIV_ONLY
    run_job(3'b010, 16, 0, 0, 0, 0, 0, 6, 2, 0, 1'b0, 1'b0);
    // illegal command, zero length
    run_job(3'b011, 16, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    idle(1);
    run_job(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    // mid-job start pulses ignored
    run_job(3'b000, 32, 1, 6, 1, 2, 1, 6, 1, 0, 1'b1, 1'b0);
    // done coincident with grant, busy held 3 more cycles
    run_job(3'b101, 8, 1, 0, 3, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    // abort inside the divide wait
    run_job(3'b000, 24, 1, 3, 1, 1, 1, 5, 1, 2, 1'b0, 1'b0);
    idle(1);
    // reset during the accumulate wait
    run_job(3'b000, 40, 1, 6, 2, 1, 1, 4, 1, 0, 1'b0, 1'b1);
    idle(2);

    for (int j = 0; j < 40; j++) begin
      rc = 3'($urandom_range(0, 7));
      rl = ($urandom_range(0, 7) == 0) ? '0 : LEN_W'($urandom_range(1, 4096));
      run_job(rc, rl,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 8)), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 6)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 8)), int'($urandom_range(0, 4)),
              ($urandom_range(0, 3) == 0) ? 1 : 0,
              1'($urandom_range(0, 2) == 0), 1'b0);
      idle(int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
